// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch-resolution controller.
package branch_ctrl_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    ADDR = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] OP_BEQ = 2'b00;
  localparam logic [1:0] OP_BNE = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/branch_ctrl_bne.sv
// Not-equal flag unit: bitwise difference vector of two operands.
module branch_ctrl_bne #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff
);

  assign diff = x ^ y;

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch resolution: latch request, compare, form next PC, hold
// the result until the fetch stage takes it.
module branch_ctrl #(
  parameter int unsigned WIDTH = branch_ctrl_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_off,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [WIDTH-1:0] res_next_pc,
  output logic [WIDTH-1:0] res_flag,
  output logic             busy
);

  import branch_ctrl_pkg::*;

  state_t           state, state_nx;
  logic             rst_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, pc_q, off_q;
  logic [WIDTH-1:0] diff;
  logic             taken_c;
  logic             accept;

  branch_ctrl_bne #(.WIDTH(WIDTH)) u_bne (
    .x    (x_q),
    .y    (y_q),
    .diff (diff)
  );

  always_comb begin
    taken_c = 1'b0;
    case (op_q)
      OP_BEQ:  taken_c = ~|diff;
      OP_BNE:  taken_c = |diff;
      OP_JMP:  taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  // rst_q keeps req_ready low for every cycle reset is held, while still
  // decoding ready purely from registers.
  always_comb begin
    state_nx  = state;
    req_ready = (state == IDLE) && !rst_q;
    busy      = (state != IDLE);
    res_valid = (state == HOLD);
    accept    = req_valid && req_ready;
    case (state)
      IDLE:    if (accept) state_nx = CMP;
      CMP:     state_nx = ADDR;
      ADDR:    state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rst_q       <= 1'b1;
      res_taken   <= 1'b0;
      res_next_pc <= '0;
      res_flag    <= '0;
    end else begin
      state <= state_nx;
      rst_q <= 1'b0;
      case (state)
        CMP: begin
          res_flag  <= diff;
          res_taken <= taken_c;
        end
        ADDR:    res_next_pc <= pc_q + WIDTH'(1) + (res_taken ? off_q : '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= req_op;
      x_q   <= req_x;
      y_q   <= req_y;
      pc_q  <= req_pc;
      off_q <= req_off;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomised and directed checks of branch_ctrl against a transaction-level model.
module tb_branch_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, req_valid, req_ready, res_valid, res_ready, res_taken, busy;
  logic [1:0]   req_op;
  logic [W-1:0] req_x, req_y, req_pc, req_off, res_next_pc, res_flag;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_pc(req_pc), .req_off(req_off),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_next_pc(res_next_pc), .res_flag(res_flag), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age = edges since the request was taken (-1 when idle).
  // Results are computed in full at acceptance and become visible at age 1/2.
  int           age = -1;
  bit           m_rst_prev = 1'b1;
  bit           p_taken, m_taken;
  logic [W-1:0] p_flag, p_npc, m_flag, m_npc;

  always @(posedge clk) begin
    bit rdy;
    rdy = (age < 0) && !m_rst_prev;
    if (reset) begin
      age = -1; m_rst_prev = 1'b1;
      m_taken = 1'b0; m_flag = '0; m_npc = '0;
    end else begin
      m_rst_prev = 1'b0;
      if (age < 0) begin
        if (req_valid && rdy) begin
          p_flag  = req_x ^ req_y;
          p_taken = (req_op == 2'd0) ? (req_x == req_y) :
                    (req_op == 2'd1) ? (req_x != req_y) : (req_op == 2'd2);
          p_npc   = req_pc + 16'd1 + (p_taken ? req_off : 16'd0);
          age = 0;
        end
      end else if (age == 0) begin
        age = 1; m_flag = p_flag; m_taken = p_taken;
      end else if (age == 1) begin
        age = 2; m_npc = p_npc;
      end else if (res_ready) begin
        age = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",   32'(req_ready),   32'((age < 0) && !m_rst_prev));
      check("busy",        32'(busy),        32'(age >= 0));
      check("res_valid",   32'(res_valid),   32'(age == 2));
      check("res_taken",   32'(res_taken),   32'(m_taken));
      check("res_flag",    32'(res_flag),    32'(m_flag));
      check("res_next_pc", 32'(res_next_pc), 32'(m_npc));
    end
  end

  task automatic run_req(input logic [1:0] op, input logic [W-1:0] x, y, pc, off,
                         input bit e_taken, input logic [W-1:0] e_npc, e_flag);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_pc = pc; req_off = off;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency",  32'(n),           32'd3);
    check("d_taken",  32'(res_taken),   32'(e_taken));
    check("d_nextpc", 32'(res_next_pc), 32'(e_npc));
    check("d_flag",   32'(res_flag),    32'(e_flag));
    @(negedge clk);
    check("d_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; res_ready = 1'b0;
    req_x = '0; req_y = '0; req_pc = '0; req_off = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_npc",   32'(res_next_pc), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 32'd1);

    run_req(2'b01, 16'h1234, 16'h1234, 16'h0010, 16'h0005, 1'b0, 16'h0011, 16'h0000);
    run_req(2'b00, 16'hA5A5, 16'hA5A5, 16'h0010, 16'hFFFE, 1'b1, 16'h000F, 16'h0000);
    run_req(2'b01, 16'h8000, 16'h0000, 16'hFFFF, 16'h0003, 1'b1, 16'h0003, 16'h8000);
    run_req(2'b10, 16'h0042, 16'h0042, 16'h0100, 16'h0010, 1'b1, 16'h0111, 16'h0000);
    run_req(2'b11, 16'h0042, 16'h0042, 16'h0100, 16'h0010, 1'b0, 16'h0101, 16'h0000);

    // Backpressure with a competing request parked on the inputs.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_x = 16'h00F0; req_y = 16'h000F;
    req_pc = 16'h0200; req_off = 16'h0020; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_op = 2'b00; req_x = 16'h1111; req_y = 16'h1111; req_pc = 16'h0300; req_off = 16'h0004;
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",  32'(res_valid),   32'd1);
      check("bp_ready",  32'(req_ready),   32'd0);
      check("bp_flag",   32'(res_flag),    32'h00FF);
      check("bp_nextpc", 32'(res_next_pc), 32'h0221);
      check("bp_taken",  32'(res_taken),   32'd1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_busy",  32'(busy),      32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp2_nextpc", 32'(res_next_pc), 32'h0305);
    check("bp2_taken",  32'(res_taken),   32'd1);
    @(negedge clk);

    // Reset while the request sits in ADDR.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_pc = 16'h0400; req_off = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ra_busy",   32'(busy),        32'd0);
    check("ra_valid",  32'(res_valid),   32'd0);
    check("ra_ready",  32'(req_ready),   32'd0);
    check("ra_taken",  32'(res_taken),   32'd0);
    check("ra_flag",   32'(res_flag),    32'd0);
    check("ra_nextpc", 32'(res_next_pc), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ra_novalid", 32'(res_valid), 32'd0);
    end
    run_req(2'b00, 16'h0001, 16'h0002, 16'h0500, 16'h0007, 1'b0, 16'h0501, 16'h0003);

    // Random traffic, with the model checking every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset     = ($urandom % 64) == 0;
      req_valid = $urandom % 2;
      req_op    = 2'($urandom);
      req_x     = 16'($urandom);
      req_y     = (($urandom % 3) == 0) ? req_x : 16'($urandom);
      req_pc    = 16'($urandom);
      req_off   = 16'($urandom);
      res_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
